imm_encode_pipe: RTL and testbench

- Inverse of the immediate extender: packs a 32-bit signed/unsigned immediate plus register/function fields into a 32-bit RV32I instruction word.
- Used by the instruction-generation path: self-test program builder and testbench stimulus feeding instruction memory.
- Two-stage valid/ready pipeline with per-format range checking and a saturating error counter.

---
 rtl/imm_encode_pipe_pkg.sv | 46 ++++
 rtl/imm_encode_pipe_if.sv | 30 +++
 rtl/imm_pack_comb.sv | 46 ++++
 rtl/imm_encode_pipe.sv | 76 +++++++
 tb/tb_imm_encode_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_encode_pipe_pkg.sv
// imm_encode_pipe_pkg
//   Shared definitions for the immediate encoder pipeline.
//   - imm_sel encodings, common to the immediate extender and the control unit
//   - RV32I major opcode constants
//   - req_t: one encode request (format, immediate, register/function fields)
//   - fits_signed(): checks that an immediate survives truncation to a signed field
package imm_encode_pipe_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } req_t;

  // True when v[31:msb] are all copies of the sign bit, i.e. v fits in a
  // signed field whose top bit is v[msb].
  function automatic logic fits_signed(input logic [31:0] v, input int msb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= msb && v[i] != v[31]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_encode_pipe_if.sv
// imm_encode_pipe_if
//   Request and response handshake bundle of the immediate encoder.
//   Request : in_valid/in_ready, imm_sel, imm, opcode, rd, funct3, rs1, rs2
//   Response: out_valid/out_ready, instr, range_err
//   master = request producer / response consumer, slave = the encoder.
interface imm_encode_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        range_err;

  modport master (
    output in_valid, imm_sel, imm, opcode, rd, funct3, rs1, rs2, out_ready,
    input  in_ready, out_valid, instr, range_err
  );

  modport slave (
    input  in_valid, imm_sel, imm, opcode, rd, funct3, rs1, rs2, out_ready,
    output in_ready, out_valid, instr, range_err
  );
endinterface

// File: rtl/imm_pack_comb.sv
// imm_pack_comb
//   Purely combinational RV32I immediate packer.
//   req   in  : format select, immediate and register/function fields
//   instr out : packed instruction word (instr[6:0] is always the opcode)
//   err   out : immediate not representable in the format, or invalid select
//   On err the word still carries the truncated immediate bits.
module imm_pack_comb
  import imm_encode_pipe_pkg::*;
(
  input  req_t        req,
  output logic [31:0] instr,
  output logic        err
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    instr = {25'b0, req.opcode};
    err   = 1'b1;
    unique case (req.sel)
      IMM_I: begin
        instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        err   = !fits_signed(req.imm, 11);
      end
      IMM_S: begin
        instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        err   = !fits_signed(req.imm, 11);
      end
      IMM_B: begin
        instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                 req.imm[4:1], req.imm[11], req.opcode};
        err   = req.imm[0] || !fits_signed(req.imm, 12);
      end
      IMM_U: begin
        instr = {req.imm[31:12], req.rd, req.opcode};
        err   = |req.imm[11:0];
      end
      IMM_J: begin
        instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
        err   = req.imm[0] || !fits_signed(req.imm, 20);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encode_pipe.sv
// imm_encode_pipe
//   Two-stage valid/ready pipeline packing an immediate plus register and
//   function fields into an RV32I instruction word.
//   clk     in  : rising-edge clock
//   rst     in  : synchronous active-high reset, drops all in-flight requests
//   bus     if  : slave side of imm_encode_pipe_if (request in, instr out)
//   err_cnt out : saturating count of erroneous words that entered stage 2
//   S1 holds the raw request; S2 holds the packed word and drives the bus.
module imm_encode_pipe
  import imm_encode_pipe_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  imm_encode_pipe_if.slave     bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  req_t        s1_req;
  logic        s1_valid;
  logic        out_valid_q;
  logic [31:0] instr_q;
  logic        range_err_q;
  logic [31:0] pack_instr;
  logic        pack_err;
  logic        s2_free;
  logic        accept;

  // S2 can load when empty or when its word leaves this cycle; out_ready is
  // allowed to reach in_ready combinationally, in_valid never is.
  assign s2_free      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.range_err = range_err_q;

  imm_pack_comb u_pack (
    .req   (s1_req),
    .instr (pack_instr),
    .err   (pack_err)
  );

  // NOTE: the S1 payload is qualified by s1_valid, so it is deliberately left
  // out of reset; only control state and the visible outputs are cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_req <= '{sel: bus.imm_sel, imm: bus.imm, opcode: bus.opcode, rd: bus.rd,
                  funct3: bus.funct3, rs1: bus.rs1, rs2: bus.rs2};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      range_err_q <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (s2_free) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          instr_q     <= pack_instr;
          range_err_q <= pack_err;
          // Counted on entry to S2, independent of when the consumer takes it.
          if (pack_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_encode_pipe.sv
// tb_imm_encode_pipe
//   Table-driven and randomized checks of imm_encode_pipe: encodings, range
//   errors, latency, backpressure, counter saturation and mid-stream reset.
module tb_imm_encode_pipe;
  import imm_encode_pipe_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  sel;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    req_t        r;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] err_cnt;
  logic       rand_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int errcnt_model = 0;
  exp_t q[$];

  logic        stall_prev = 1'b0;
  logic [31:0] held_instr;
  logic        held_err;

  imm_encode_pipe_if bus ();

  imm_encode_pipe #(.ERR_CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference immediate extender, used for the round-trip property.
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] sel);
    case (sel)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  // Behavioural model: errors from signed ranges, fields placed with shifts.
  function automatic exp_t model(input req_t r);
    exp_t        e;
    int          s;
    logic [31:0] v;
    logic [31:0] regs;
    s    = $signed(r.imm);
    v    = {25'b0, r.opcode};
    regs = (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.funct3) << 12);
    e.err = 1'b1;
    case (r.sel)
      3'd0: begin
        v = v | ((r.imm & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.funct3) << 12) | (32'(r.rd) << 7);
        e.err = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        v = v | (((r.imm >> 5) & 32'h7F) << 25) | regs | ((r.imm & 32'h1F) << 7);
        e.err = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        v = v | (((r.imm >> 12) & 32'h1) << 31) | (((r.imm >> 5) & 32'h3F) << 25) | regs
              | (((r.imm >> 1) & 32'hF) << 8) | (((r.imm >> 11) & 32'h1) << 7);
        e.err = (r.imm % 2 != 0) || (s < -4096) || (s > 4095);
      end
      3'd3: begin
        v = v | (r.imm & 32'hFFFFF000) | (32'(r.rd) << 7);
        e.err = (r.imm % 4096) != 0;
      end
      3'd4: begin
        v = v | (((r.imm >> 20) & 32'h1) << 31) | (((r.imm >> 1) & 32'h3FF) << 21)
              | (((r.imm >> 11) & 32'h1) << 20) | (((r.imm >> 12) & 32'hFF) << 12) | (32'(r.rd) << 7);
        e.err = (r.imm % 2 != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
      end
      default: ;
    endcase
    e.instr = v;
    e.sel   = r.sel;
    e.imm   = r.imm;
    return e;
  endfunction

  function automatic req_t mk(input logic [2:0] sel, input logic [31:0] imm, input logic [6:0] op,
                              input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                              input logic [4:0] rs2);
    req_t r;
    r = '{sel: sel, imm: imm, opcode: op, rd: rd, funct3: f3, rs1: rs1, rs2: rs2};
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input req_t r, input exp_t e);
    int  n = 0;
    bit  ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.imm_sel  = r.sel;
    bus.imm      = r.imm;
    bus.opcode   = r.opcode;
    bus.rd       = r.rd;
    bus.funct3   = r.funct3;
    bus.rs1      = r.rs1;
    bus.rs2      = r.rs2;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (ok) begin
      q.push_back(e);
      if (e.err && errcnt_model < 255) errcnt_model++;
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
    check("err_cnt_after_drain", 32'(err_cnt), 32'(errcnt_model));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    errcnt_model = 0;
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (stall_prev && bus.out_valid) begin
        check("hold_instr", bus.instr, held_instr);
        check("hold_err", 32'(bus.range_err), 32'(held_err));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_instr = bus.instr;
      held_err   = bus.range_err;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("instr", bus.instr, e.instr);
          check("range_err", 32'(bus.range_err), 32'(e.err));
          if (!e.err && e.sel <= 3'd4) check("round_trip", extend(bus.instr, e.sel), e.imm);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vt[16];
    req_t  r;
    exp_t  e;
    req_t  bp[4];
    logic [31:0] imm;

    vt[0]  = '{mk(IMM_I, 32'h00000005, OP_IMM,    5'd1, 3'd0, 5'd0, 5'd0),  32'h00500093, 1'b0};
    vt[1]  = '{mk(IMM_B, 32'hFFFFFFFC, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2),  32'hFE208EE3, 1'b0};
    vt[2]  = '{mk(IMM_B, 32'hFFFFFFFD, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2),  32'hFE208EE3, 1'b1};
    vt[3]  = '{mk(IMM_U, 32'h12345000, OP_LUI,    5'd5, 3'd0, 5'd0, 5'd0),  32'h123452B7, 1'b0};
    vt[4]  = '{mk(IMM_J, 32'h00000800, OP_JAL,    5'd1, 3'd0, 5'd0, 5'd0),  32'h001000EF, 1'b0};
    vt[5]  = '{mk(IMM_I, 32'h00000800, OP_IMM,    5'd1, 3'd0, 5'd0, 5'd0),  32'h80000093, 1'b1};
    vt[6]  = '{mk(IMM_S, 32'hFFFFFFF8, OP_STORE,  5'd0, 3'd2, 5'd1, 5'd2),  32'hFE20AC23, 1'b0};
    vt[7]  = '{mk(IMM_U, 32'h12345001, OP_LUI,    5'd5, 3'd0, 5'd0, 5'd0),  32'h123452B7, 1'b1};
    vt[8]  = '{mk(IMM_J, 32'h00000001, OP_JAL,    5'd1, 3'd0, 5'd0, 5'd0),  32'h000000EF, 1'b1};
    vt[9]  = '{mk(IMM_J, 32'hFFF00000, OP_JAL,    5'd0, 3'd0, 5'd0, 5'd0),  32'h8000006F, 1'b0};
    vt[10] = '{mk(IMM_I, 32'h000007FF, OP_IMM,    5'd1, 3'd0, 5'd0, 5'd0),  32'h7FF00093, 1'b0};
    vt[11] = '{mk(IMM_I, 32'hFFFFF800, OP_IMM,    5'd1, 3'd0, 5'd0, 5'd0),  32'h80000093, 1'b0};
    vt[12] = '{mk(3'b101, 32'h00000004, OP_REG,   5'd3, 3'd1, 5'd4, 5'd5),  32'h00000033, 1'b1};
    vt[13] = '{mk(IMM_B, 32'h00001000, OP_BRANCH, 5'd0, 3'd0, 5'd1, 5'd2),  32'h80208063, 1'b1};
    vt[14] = '{mk(IMM_J, 32'h00100000, OP_JAL,    5'd1, 3'd0, 5'd0, 5'd0),  32'h800000EF, 1'b1};
    vt[15] = '{mk(IMM_I, 32'h00000005, OP_IMM,    5'd1, 3'd0, 5'd0, 5'd31), 32'h00500093, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.imm_sel   = '0;
    bus.imm       = '0;
    bus.opcode    = '0;
    bus.rd        = '0;
    bus.funct3    = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_range_err", 32'(bus.range_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: out_valid appears two cycles after the accepting cycle
    e = '{vt[0].instr, vt[0].err, vt[0].r.sel, vt[0].r.imm};
    send(vt[0].r, e);
    @(negedge clk);
    check("lat_cycle1_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_out_valid", 32'(bus.out_valid), 32'd1);
    drain();

    // Table vectors, streamed back to back
    for (int i = 0; i < 16; i++) begin
      e = '{vt[i].instr, vt[i].err, vt[i].r.sel, vt[i].r.imm};
      send(vt[i].r, e);
    end
    drain();

    // Backpressure: consumer stalls for three cycles
    do_reset();
    for (int i = 0; i < 4; i++)
      bp[i] = mk(IMM_I, 32'(i * 3 + 1), OP_IMM, 5'(i + 1), 3'd0, 5'd2, 5'd0);
    bus.out_ready = 1'b0;
    send(bp[0], model(bp[0]));
    send(bp[1], model(bp[1]));
    bus.in_valid = 1'b1;
    bus.imm_sel  = bp[2].sel;
    bus.imm      = bp[2].imm;
    bus.rd       = bp[2].rd;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_head_instr", bus.instr, model(bp[0]).instr);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(bp[2], model(bp[2]));
    send(bp[3], model(bp[3]));
    drain();

    // Invalid select and counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = mk(3'b111, $urandom, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom));
      e = '{{25'b0, r.opcode}, 1'b1, r.sel, r.imm};
      send(r, e);
    end
    drain();
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);

    // Reset with both stages full
    do_reset();
    bus.out_ready = 1'b0;
    send(vt[5].r, model(vt[5].r));
    send(vt[2].r, model(vt[2].r));
    @(negedge clk);
    check("mid_err_cnt_on_s2_entry", 32'(err_cnt), 32'd1);
    check("mid_out_valid_full", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    errcnt_model = 0;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_err_cnt", 32'(err_cnt), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(vt[3].r, model(vt[3].r));
    drain();

    // Randomized requests against the model, random consumer stalls
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm = 32'($urandom_range(0, (1 << 22) - 1)) - 32'(1 << 21);
        default: imm = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 3) == 0);
      endcase
      r = mk(($urandom_range(0, 7) == 7) ? 3'(5 + $urandom_range(0, 2)) : 3'($urandom_range(0, 4)),
             imm, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom));
      send(r, model(r));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
